// File: rtl/rx78_ram_dump_if.sv
// rx78_ram_dump_if
// Bundles the signals around the RAM dump responder:
//   - HPS ioctl side : ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr in;
//                      ioctl_din, ioctl_wait back to the HPS.
//   - CPU bus request: hold_req out, hold_ack back from the Z80.
//   - RAM read port  : mem_addr, mem_rd out, mem_q back (one-cycle latency).
//   - busy           : session-in-progress flag for the top level.
// master = the surrounding system (HPS, CPU, RAM mux); slave = the responder.
interface rx78_ram_dump_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        hold_req;
  logic        hold_ack;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q;
  logic        busy;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, hold_ack, mem_q,
    input  ioctl_din, ioctl_wait, hold_req, mem_addr, mem_rd, busy
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, hold_ack, mem_q,
    output ioctl_din, ioctl_wait, hold_req, mem_addr, mem_rd, busy
  );
endinterface

// File: rtl/rx78_ram_dump.sv
// rx78_ram_dump
// Read-side responder for HPS uploads (core-to-HPS save). While an upload
// with index INDEX is running, the Z80 is held off the bus and each HPS read
// strobe is answered with the byte at BASE + offset from the extension RAM.
// Offsets at or beyond SIZE read back as 8'hff without touching the RAM.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - rx78_ram_dump_if.slave (ioctl, bus-request and RAM read signals)
// All outputs are registered.
module rx78_ram_dump #(
  parameter logic [7:0]  INDEX = 8'd2,
  parameter logic [15:0] BASE  = 16'h6000,
  parameter logic [24:0] SIZE  = 25'h05000
) (
  input logic           clk,
  input logic           reset,
  rx78_ram_dump_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HOLD, READY, RD, LAT} state_t;

  state_t      state;
  logic        pending;
  logic        oor_q;

  logic        active;
  logic        strobe_oor;
  logic [15:0] strobe_addr;
  logic        take;

  assign active      = bus.ioctl_upload && (bus.ioctl_index == INDEX);
  assign strobe_oor  = (bus.ioctl_addr >= SIZE);
  assign strobe_addr = BASE + bus.ioctl_addr[15:0];

  // A strobe is latched only while no read is outstanding; strobes during
  // RD/LAT (or while a restarted read is still pending) are ignored.
  assign take = bus.ioctl_rd && !pending &&
                (state == IDLE || state == HOLD || state == READY);

  // Single FSM: a dropped session wins over everything else, and a lost
  // hold_ack parks the FSM in HOLD with the request kept pending so the
  // read restarts from RD once the bus comes back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pending        <= 1'b0;
      oor_q          <= 1'b0;
      bus.ioctl_din  <= 8'h00;
      bus.ioctl_wait <= 1'b0;
      bus.hold_req   <= 1'b0;
      bus.mem_addr   <= 16'h0000;
      bus.mem_rd     <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      // busy outlives the session until the CPU has actually taken the bus back
      bus.busy <= active || (bus.busy && bus.hold_ack);

      if (!active) begin
        state          <= IDLE;
        pending        <= 1'b0;
        bus.hold_req   <= 1'b0;
        bus.mem_rd     <= 1'b0;
        bus.ioctl_wait <= 1'b0;
      end else begin
        bus.hold_req <= 1'b1;

        if (take) begin
          pending        <= 1'b1;
          bus.ioctl_wait <= 1'b1;
          bus.mem_addr   <= strobe_addr;
          oor_q          <= strobe_oor;
        end

        case (state)
          IDLE: state <= HOLD;

          HOLD: begin
            if (bus.hold_ack) state <= READY;
          end

          READY: begin
            if (!bus.hold_ack) begin
              state <= HOLD;
            end else if (pending || bus.ioctl_rd) begin
              state      <= RD;
              // out-of-range requests run the same sequence without a RAM read
              bus.mem_rd <= pending ? !oor_q : !strobe_oor;
            end
          end

          RD: begin
            bus.mem_rd <= 1'b0;
            state      <= bus.hold_ack ? LAT : HOLD;
          end

          LAT: begin
            if (!bus.hold_ack) begin
              state <= HOLD;
            end else begin
              bus.ioctl_din  <= oor_q ? 8'hff : bus.mem_q;
              bus.ioctl_wait <= 1'b0;
              pending        <= 1'b0;
              state          <= READY;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx78_ram_dump.sv
// tb_rx78_ram_dump
// Directed bench for rx78_ram_dump: a small RAM model with one-cycle read
// latency and a CPU model that answers hold_req four cycles later.
module tb_rx78_ram_dump;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx78_ram_dump_if bus();

  rx78_ram_dump dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // CPU and RAM models
  logic [7:0] ram [0:65535];
  logic [7:0] mem_q_r  = 8'h00;
  logic [3:0] ack_sh   = 4'b0000;
  logic       ack_en   = 1'b1;
  int         rd_count = 0;
  int         early_rd = 0;

  assign bus.hold_ack = ack_sh[3] & ack_en;
  assign bus.mem_q    = mem_q_r;

  always @(posedge clk) begin
    ack_sh <= {ack_sh[2:0], bus.hold_req};
    if (bus.mem_rd) begin
      mem_q_r  <= ram[bus.mem_addr];
      rd_count <= rd_count + 1;
      if (!bus.hold_ack) early_rd <= early_rd + 1;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic upload, input logic [7:0] idx,
                               input logic rd, input logic [24:0] addr);
    bus.ioctl_upload = upload;
    bus.ioctl_index  = idx;
    bus.ioctl_rd     = rd;
    bus.ioctl_addr   = addr;
  endtask

  // Start an index-2 session and stop in the first READY cycle.
  task automatic acquire();
    int n;
    applyStimulus(1'b1, 8'd2, 1'b0, 25'h0);
    tick();
    checkOutput("hold_req rise", bus.hold_req, 1);
    n = 0;
    while (!bus.hold_ack && n < 20) begin
      tick();
      n++;
    end
    checkOutput("acquire bound", n < 20, 1);
    tick();
    checkOutput("busy in session", bus.busy, 1);
  endtask

  // Strobe in cycle T, check the T+1..T+3 sequence.
  task automatic doRead(input logic [24:0] addr, input logic [7:0] exp,
                        input logic oor, input string tag);
    int          rd0;
    logic [15:0] ea;
    rd0 = rd_count;
    ea  = 16'h6000 + addr[15:0];
    applyStimulus(1'b1, 8'd2, 1'b1, addr);
    tick();
    applyStimulus(1'b1, 8'd2, 1'b0, addr);
    checkOutput({tag, " wait T+1"}, bus.ioctl_wait, 1);
    checkOutput({tag, " mem_rd T+1"}, bus.mem_rd, !oor);
    checkOutput({tag, " mem_addr"}, bus.mem_addr, ea);
    tick();
    checkOutput({tag, " wait T+2"}, bus.ioctl_wait, 1);
    checkOutput({tag, " mem_rd T+2"}, bus.mem_rd, 0);
    tick();
    checkOutput({tag, " wait T+3"}, bus.ioctl_wait, 0);
    checkOutput({tag, " din"}, bus.ioctl_din, exp);
    checkOutput({tag, " ram reads"}, rd_count - rd0, oor ? 0 : 1);
  endtask

  task automatic endSession();
    int n;
    applyStimulus(1'b0, 8'd2, 1'b0, 25'h0);
    tick();
    checkOutput("end hold_req", bus.hold_req, 0);
    checkOutput("end wait", bus.ioctl_wait, 0);
    n = 0;
    while (bus.hold_ack && n < 20) begin
      tick();
      n++;
    end
    checkOutput("release bound", n < 20, 1);
    checkOutput("busy before ack seen", bus.busy, 1);
    tick();
    checkOutput("busy after release", bus.busy, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h6000] = 8'hA5;
    ram[16'h6001] = 8'h3C;
    ram[16'h6002] = 8'h5A;
    ram[16'hAFFF] = 8'h77;

    // Reset with a matching strobe present: reset wins
    reset = 1'b1;
    applyStimulus(1'b1, 8'd2, 1'b1, 25'h0);
    tick();
    tick();
    checkOutput("reset din", bus.ioctl_din, 8'h00);
    checkOutput("reset wait", bus.ioctl_wait, 0);
    checkOutput("reset hold_req", bus.hold_req, 0);
    checkOutput("reset mem_addr", bus.mem_addr, 16'h0000);
    checkOutput("reset mem_rd", bus.mem_rd, 0);
    checkOutput("reset busy", bus.busy, 0);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'h0);
    tick();
    reset = 1'b0;
    tick();

    // Basic reads, boundary and out-of-range offsets
    acquire();
    doRead(25'h0_0000, 8'hA5, 1'b0, "addr0");
    doRead(25'h0_0001, 8'h3C, 1'b0, "addr1");
    doRead(25'h0_4FFF, 8'h77, 1'b0, "last");
    doRead(25'h0_5000, 8'hFF, 1'b1, "size");
    doRead(25'h1_0000, 8'hFF, 1'b1, "wrap");

    // hold_ack lost during LAT: back to HOLD, read restarts after return
    applyStimulus(1'b1, 8'd2, 1'b1, 25'h1);
    tick();
    applyStimulus(1'b1, 8'd2, 1'b0, 25'h1);
    tick();
    ack_en = 1'b0;
    tick();
    checkOutput("ackdrop wait", bus.ioctl_wait, 1);
    checkOutput("ackdrop hold_req", bus.hold_req, 1);
    checkOutput("ackdrop din kept", bus.ioctl_din, 8'hFF);
    ack_en = 1'b1;
    n = 0;
    while (bus.ioctl_wait && n < 20) begin
      tick();
      n++;
    end
    checkOutput("ackdrop restart cycles", n, 4);
    checkOutput("ackdrop din", bus.ioctl_din, 8'h3C);
    endSession();

    // Strobe before the bus is granted
    applyStimulus(1'b1, 8'd2, 1'b1, 25'h2);
    tick();
    applyStimulus(1'b1, 8'd2, 1'b0, 25'h2);
    checkOutput("early hold_req", bus.hold_req, 1);
    checkOutput("early wait", bus.ioctl_wait, 1);
    n = 1;
    while (bus.ioctl_wait && n < 40) begin
      tick();
      n++;
    end
    checkOutput("early latency", n, 9);
    checkOutput("early din", bus.ioctl_din, 8'h5A);
    checkOutput("no read before ack", early_rd, 0);

    // Upload dropped in T+1 of a read
    applyStimulus(1'b1, 8'd2, 1'b1, 25'h0);
    tick();
    checkOutput("drop wait T+1", bus.ioctl_wait, 1);
    applyStimulus(1'b0, 8'd2, 1'b0, 25'h0);
    tick();
    checkOutput("drop hold_req", bus.hold_req, 0);
    checkOutput("drop wait", bus.ioctl_wait, 0);
    checkOutput("drop mem_rd", bus.mem_rd, 0);
    checkOutput("drop din kept", bus.ioctl_din, 8'h5A);
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    checkOutput("drop busy bound", n < 20, 1);
    acquire();
    doRead(25'h0_0000, 8'hA5, 1'b0, "resession");
    endSession();

    // Wrong index: nothing happens
    n = rd_count;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'd1, i[0], 25'h0);
      tick();
      checkOutput("idx1 hold_req", bus.hold_req, 0);
      checkOutput("idx1 wait", bus.ioctl_wait, 0);
    end
    checkOutput("idx1 busy", bus.busy, 0);
    checkOutput("idx1 din", bus.ioctl_din, 8'hA5);
    checkOutput("idx1 ram reads", rd_count - n, 0);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'h0);
    tick();

    // Reset during LAT
    acquire();
    applyStimulus(1'b1, 8'd2, 1'b1, 25'h1);
    tick();
    applyStimulus(1'b1, 8'd2, 1'b0, 25'h1);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 25'h0);
    tick();
    checkOutput("lat reset din", bus.ioctl_din, 8'h00);
    checkOutput("lat reset wait", bus.ioctl_wait, 0);
    checkOutput("lat reset hold_req", bus.hold_req, 0);
    checkOutput("lat reset mem_addr", bus.mem_addr, 16'h0000);
    checkOutput("lat reset mem_rd", bus.mem_rd, 0);
    checkOutput("lat reset busy", bus.busy, 0);
    reset = 1'b0;
    n = 0;
    while (bus.hold_ack && n < 20) begin
      tick();
      n++;
    end
    checkOutput("post reset release bound", n < 20, 1);
    tick();
    acquire();
    doRead(25'h0_0000, 8'hA5, 1'b0, "fresh");
    endSession();
    checkOutput("final no early reads", early_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rx78_ram_dump.md
# rx78_ram_dump

Read-side responder for the HPS file interface: while the HPS runs an upload (core-to-HPS save) with a matching index, this block takes the Z80 off the bus, reads the requested bytes from the extension-RAM port, and returns them one per HPS read strobe. It complements the existing cartridge download path, which only writes. It sits in the top level between the HPS ioctl signals, the CPU bus-request handshake and a read port muxed onto the 32k extension RAM.

## Interface
- INDEX, 8'd2: ioctl index this block responds to.
- BASE, 16'h6000: CPU address of dump byte 0.
- SIZE, 25'h05000: dump length in bytes (6000–AFFF window); bytes at or above SIZE read as 8'hff.

- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  8  file index of the session.
- ioctl_rd  in  1  one-cycle read strobe for the byte at ioctl_addr.
- ioctl_addr  in  25  byte offset being requested; stable from the ioctl_rd cycle until ioctl_wait falls.
- ioctl_din  out  8  returned byte; valid when ioctl_wait is low after a strobe.
- ioctl_wait  out  1  high while a requested byte is not yet valid.
- hold_req  out  1  request that the CPU release the bus (drives busrq_n inverted).
- hold_ack  in  1  CPU bus released (busak_n inverted).
- mem_addr  out  16  CPU-space read address to the RAM mux.
- mem_rd  out  1  read enable; RAM returns mem_q one cycle later.
- mem_q  in  8  RAM read data.
- busy  out  1  high from session start until the bus is returned.

## Operation
- active = ioctl_upload && ioctl_index == INDEX, evaluated every cycle.
- States:
  - IDLE: hold_req=0; on active go to HOLD.
  - HOLD: hold_req=1; on hold_ack go to READY.
  - READY: wait for ioctl_rd.
  - RD: drive mem_addr/mem_rd.
  - LAT: capture the byte.
  - Then return to READY.
- ioctl_rd in IDLE or HOLD is accepted: the block latches a pending flag, raises ioctl_wait, and services the read on entry to READY.
- ioctl_rd while in RD or LAT (a protocol violation) is ignored; no second read.
- mem_addr = BASE + ioctl_addr[15:0], modulo 2^16; latched in the strobe cycle.
- Range check uses the full 25-bit ioctl_addr. If ioctl_addr >= SIZE, RD keeps mem_rd=0 and LAT captures 8'hff; the same state sequence and latency apply.
- hold_req stays high for the entire session and is not toggled per byte.
- When active drops (upload end or index change) in any non-IDLE state, at the next edge:
  - state goes to IDLE;
  - hold_req, mem_rd and ioctl_wait go to 0;
  - busy falls one cycle after hold_ack is seen low;
  - ioctl_din holds its last value.
- If hold_ack drops while in READY/RD/LAT, return to HOLD. Any in-flight read is retained as pending and restarted from RD once hold_ack returns.
- Strobes with the wrong index are ignored: ioctl_wait stays 0 and ioctl_din is unchanged.

## Timing
- Reset values: ioctl_din=8'h00, ioctl_wait=0, hold_req=0, mem_addr=0, mem_rd=0, busy=0; state IDLE; pending=0.
- All outputs are registered.
- Bus acquisition: hold_req rises the cycle after active is first sampled. READY is entered the cycle after hold_ack is sampled high.
- Read latency with bus held, strobe in cycle T:
  - T+1: ioctl_wait=1, mem_rd=1 (or 0 if out of range), mem_addr valid.
  - T+2: mem_q valid, captured at the end of the cycle; mem_rd=0.
  - T+3: ioctl_din valid, ioctl_wait=0, state READY.
- Back-to-back: the earliest accepted next strobe is T+3.
- Simultaneous reset and strobe: reset wins.
- Simultaneous active-drop and strobe: the drop wins; the strobe is discarded.

## Test plan
- Preload RAM[6000]=A5, RAM[6001]=3C. Upload with index 2; hold_ack is returned 4 cycles after hold_req. Strobe addr 0 in READY -> ioctl_wait high for exactly 2 cycles, ioctl_din=A5 at T+3. Strobe addr 1 -> 3C.
- Strobe issued before hold_ack -> ioctl_wait stays high through the acquisition; byte returned 3 cycles after READY entry; mem_rd never asserted before hold_ack.
- ioctl_addr = 25'h05000 and 25'h1_0000 -> ioctl_din=FF, mem_rd never asserted, latency 3 cycles.
- ioctl_upload dropped in cycle T+1 of a read -> next edge: hold_req=0, ioctl_wait=0, mem_rd=0, state IDLE. The next session re-requests the bus.
- Index 1 session with strobes -> hold_req, ioctl_wait, mem_rd all stay 0; ioctl_din unchanged.
- Reset asserted in LAT -> all outputs at reset values next cycle, hold_req=0. A fresh session then reads RAM[6000] correctly.
